// File: rtl/chunked_serial_adder_pkg.sv
// Shared definitions for the chunked serial adder: FSM states and parameter helpers.
package chunked_serial_adder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Number of CHUNK-wide slices that make up one WIDTH-wide operand.
  function automatic int unsigned calc_nchunk(input int unsigned width, input int unsigned chunk);
    return (chunk == 0) ? 0 : width / chunk;
  endfunction

  // True when the width/chunk pair describes a whole number of chunks.
  function automatic bit width_ok(input int unsigned width, input int unsigned chunk);
    if (chunk == 0 || chunk > width) return 1'b0;
    return (width % chunk) == 0;
  endfunction

  // Bits needed to count n items, never less than one.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunked_serial_adder_chunk_adder.sv
// Combinational CHUNK-bit adder reused once per cycle by the serial adder.
module chunk_adder #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  // One extra bit on each term captures the chunk carry-out.
  assign {cout, s} = {1'b0, a} + {1'b0, b} + (CHUNK + 1)'(cin);

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder: sums two WIDTH-bit operands CHUNK bits per clock with a registered carry.
module chunked_serial_adder
  import chunked_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             overflow
);

  localparam int unsigned NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int unsigned IDXW   = min1_clog2(NCHUNK);
  localparam int unsigned BASEW  = min1_clog2(WIDTH);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  // Reject parameter pairs that do not split into whole chunks.
  generate
    if (!width_ok(WIDTH, CHUNK)) begin : g_bad_params
      $error("chunked_serial_adder: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  s_q, s_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;

  logic [BASEW-1:0]  chunk_base;
  logic [CHUNK-1:0]  a_chunk, b_chunk, s_chunk;
  logic              c_chunk;

  // Bit offset of the active chunk; operand registers stay put and are sliced in place.
  assign chunk_base = BASEW'(32'(idx_q) * CHUNK);
  assign a_chunk    = a_q[chunk_base +: CHUNK];
  assign b_chunk    = b_q[chunk_base +: CHUNK];

  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a    (a_chunk),
    .b    (b_chunk),
    .cin  (carry_q),
    .s    (s_chunk),
    .cout (c_chunk)
  );

  // Next-state and output decode: accept in IDLE, one chunk per RUN edge, publish on the last.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        sum_d[chunk_base +: CHUNK] = s_chunk;
        carry_d = c_chunk;
        if (idx_q == IDX_LAST) begin
          idx_d   = '0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          s_d     = sum_d;
          cout_d  = c_chunk;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_d[WIDTH-1] != a_q[WIDTH-1]);
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; synchronous reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign S        = s_q;
  assign Cout     = cout_q;
  assign overflow = ovf_q;

endmodule
